// File: rtl/xilinx_reset_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a
// constant-foldable ceil(log2) used to size counters.
package xilinx_reset_pkg;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } rst_state_e;

  // Returns the number of bits needed to index 'value' distinct states.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/xilinx_reset_sync_chain.sv
// Reset synchroniser: DEPTH async-preset, clock-enabled flops in series.
// Asserts asynchronously on pre_i, deasserts synchronously after DEPTH enabled edges.
module xilinx_reset_sync_chain #(
  parameter int unsigned DEPTH = 5,
  parameter bit          INIT  = 1'b1
) (
  input  logic clk_i,
  input  logic pre_i,
  input  logic en_i,
  output logic sync_o
);

  logic [DEPTH:0] stage_in;

  assign stage_in[0] = ~INIT;

  // One FDPE-style flop per stage; CE maps onto en_i, PRE onto pre_i.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic stage_q;

    always_ff @(posedge clk_i or posedge pre_i) begin
      if (pre_i) begin
        stage_q <= INIT;
      end else if (en_i) begin
        stage_q <= stage_in[i];
      end
    end

    assign stage_in[i+1] = stage_q;
  end

  assign sync_o = stage_in[DEPTH];

endmodule

// File: rtl/xilinx_reset_sequencer.sv
// Reset controller: synchronises master and requester resets, holds all channels in
// reset for HOLD_CYCLES, then releases channel 0..NUM_CH-1 one every STAGGER cycles.
module xilinx_reset_sequencer
  import xilinx_reset_pkg::*;
#(
  parameter int unsigned DEPTH       = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] rst_req,
  output logic [NUM_CH-1:0]  rst_out,
  output logic [NUM_CH-1:0]  rst_out_n,
  output logic               done,
  output logic [NUM_SRC:0]   cause
);

  localparam int unsigned CntMaxVal = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CntW      = clog2(CntMaxVal + 1);
  localparam int unsigned ChW       = clog2(NUM_CH) + 1;

  localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]  StagLast = CntW'(STAGGER - 1);
  localparam logic [CntW-1:0]  CntSat   = {CntW{1'b1}};
  localparam logic [ChW-1:0]   LastCh   = ChW'(NUM_CH - 1);
  localparam logic [NUM_SRC:0] CauseRst = {1'b1, {NUM_SRC{1'b0}}};

  // ---------------------------------------------------------------------------
  // Synchronisers: bit NUM_SRC is the master chain, bit i follows rst_req[i]
  // ---------------------------------------------------------------------------
  logic [NUM_SRC:0] chain_out;
  logic             mst_pre;
  logic             sync_rst;

  assign mst_pre = ~rst_n;

  xilinx_reset_sync_chain #(
    .DEPTH (DEPTH),
    .INIT  (1'b1)
  ) u_sync_mst (
    .clk_i  (clk),
    .pre_i  (mst_pre),
    .en_i   (enable),
    .sync_o (chain_out[NUM_SRC])
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    xilinx_reset_sync_chain #(
      .DEPTH (DEPTH),
      .INIT  (1'b1)
    ) u_sync_src (
      .clk_i  (clk),
      .pre_i  (rst_req[i]),
      .en_i   (enable),
      .sync_o (chain_out[i])
    );
  end

  assign sync_rst = |chain_out;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  rst_state_e       state_q, state_d;
  logic [CntW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CntW-1:0]  stag_cnt_q, stag_cnt_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [NUM_SRC:0] cause_q, cause_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic [NUM_CH-1:0] rst_out_n_q, rst_out_n_d;
  logic             done_q, done_d;

  function automatic logic [CntW-1:0] cnt_inc(input logic [CntW-1:0] value);
    return (value == CntSat) ? value : value + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      ch_q        <= '0;
      cause_q     <= CauseRst;
      rst_out_q   <= '1;
      rst_out_n_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      ch_q        <= ch_d;
      cause_q     <= cause_d;
      rst_out_q   <= rst_out_d;
      rst_out_n_q <= rst_out_n_d;
      done_q      <= done_d;
    end
  end

  // ch_q counts released channels. A synchronised reset overrides everything,
  // including enable and a release due on the same edge.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    ch_d       = ch_q;
    cause_d    = cause_q;

    if (sync_rst) begin
      state_d    = StHold;
      hold_cnt_d = '0;
      stag_cnt_d = '0;
      ch_d       = '0;
      cause_d    = (state_q == StHold) ? (cause_q | chain_out) : chain_out;
    end else if (enable) begin
      unique case (state_q)
        StHold: begin
          if (hold_cnt_q >= HoldLast) begin
            hold_cnt_d = '0;
            stag_cnt_d = '0;
            ch_d       = ChW'(1);
            if (NUM_CH == 1) begin
              state_d = StRun;
            end else begin
              state_d = StRelease;
            end
          end else begin
            hold_cnt_d = cnt_inc(hold_cnt_q);
          end
        end
        StRelease: begin
          if (stag_cnt_q >= StagLast) begin
            stag_cnt_d = '0;
            ch_d       = ch_q + 1'b1;
            if (ch_q == LastCh) begin
              state_d = StRun;
            end
          end else begin
            stag_cnt_d = cnt_inc(stag_cnt_q);
          end
        end
        StRun: begin
          state_d = StRun;
        end
        default: begin
          state_d    = StHold;
          hold_cnt_d = '0;
          stag_cnt_d = '0;
          ch_d       = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the deciding edge.
  always_comb begin
    rst_out_d = '1;
    if (state_d != StHold) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        rst_out_d[k] = (ChW'(k) >= ch_d);
      end
    end
    rst_out_n_d = ~rst_out_d;
    done_d      = (state_d == StRun);
  end

  assign rst_out   = rst_out_q;
  assign rst_out_n = rst_out_n_q;
  assign done      = done_q;
  assign cause     = cause_q;

endmodule

// File: doc/xilinx_reset_sequencer.md
Name: xilinx_reset_sequencer

Overview:
- Parametrised reset controller for one clock domain.
- Synchronises a master async reset and NUM_SRC async reset-request sources through DEPTH-stage preset flops.
- Enforces a minimum hold time, then releases NUM_CH reset outputs in a staggered order, one every STAGGER cycles.
- Sits between the clock/PLL-lock logic and the datapath blocks that need ordered reset release (e.g. PHY, then MAC, then AXI fabric).

Parameters:
- DEPTH, 5: synchroniser stages per chain, >=2.
- NUM_SRC, 2: number of async active-high reset-request inputs, >=1.
- NUM_CH, 4: number of sequenced reset outputs, >=1.
- HOLD_CYCLES, 16: enabled cycles all outputs stay asserted after the synchronised reset clears, >=1.
- STAGGER, 8: enabled cycles between successive channel releases, >=1.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  master reset; asynchronous, active-low.
- enable  input  1  clock enable for the sync chains and counters.
- rst_req  input  NUM_SRC  async active-high reset requests, any pulse width.
- rst_out  output  NUM_CH  active-high resets; bit 0 is released first.
- rst_out_n  output  NUM_CH  bitwise inverse of rst_out, registered separately (not an inverter on rst_out).
- done  output  1  high when every channel is released (state RUN).
- cause  output  NUM_SRC+1  sticky source of the last reset; bit NUM_SRC = rst_n, bit i = rst_req[i].

Behaviour:
- Sync chains:
  - Master chain: async preset while rst_n low; shifts 0 on enabled edges.
  - Source chain i: async preset while rst_req[i] high; shifts 0 on enabled edges.
  - sync_rst = OR of all chain outputs.
- Reset values while rst_n low: rst_out all 1, rst_out_n all 0, done 0, cause = 1<<NUM_SRC, state HOLD, counters 0.
- States:
  - HOLD: all outputs asserted. Counter increments on enabled edges with sync_rst=0 and clears whenever sync_rst=1. At count HOLD_CYCLES go to RELEASE and deassert rst_out[0] on the same edge.
  - RELEASE: stagger counter counts enabled edges. Every STAGGER edges deassert the next channel. The edge that deasserts rst_out[NUM_CH-1] enters RUN.
  - RUN: done=1; all outputs deasserted.
- NUM_CH=1: HOLD goes directly to RUN.
- Latency: with enable high and rst_req low, rst_out[k] deasserts on rising edge DEPTH+HOLD_CYCLES+k*STAGGER, counted from the first edge with rst_n high (edge 1). done rises on the same edge as rst_out[NUM_CH-1].
- Reset request mid-operation:
  - rst_req[i] rising in RELEASE or RUN: the chain presets asynchronously. At the first rising edge sampling sync_rst=1, all outputs reassert, done drops, state becomes HOLD, counters clear.
  - cause is loaded on that edge with the OR-mask of the chains currently high. It is not updated while already in HOLD, except that it ORs in new sources.
- The full release sequence restarts from the beginning after sync_rst clears; a channel is never released out of order.
- Simultaneous sync_rst=1 and a release edge: the reset wins and no channel is released.
- enable low:
  - Chains and counters freeze; no release progresses.
  - Assertion still takes effect: preset is async and the HOLD entry ignores enable.
- Arithmetic: counters are clog2(max(HOLD_CYCLES,STAGGER)+1) bits wide, saturate, never wrap. The channel index is clog2(NUM_CH)+1 bits wide.
- Every flop in a sync chain carries ASYNC_REG and no-shift-register-extract attributes.

Decomposition:
- Shared package xilinx_reset_pkg: state encodings (HOLD, RELEASE, RUN) and a clog2 constant function.
- One sub-module, xilinx_reset_sync_chain (DEPTH, INIT=1): a generate loop of FDPE primitives with CE=enable. It is instantiated NUM_SRC+1 times.

Test Plan:
- Power-on, DEPTH=3, HOLD_CYCLES=4, STAGGER=2, NUM_CH=3, rst_n rises before edge 1 -> rst_out[0] falls at edge 7, [1] at 9, [2] at 11; done=1 at 11; cause=3'b100.
- In RUN, 1-ps-wide pulse on rst_req[1] -> all rst_out=1 and done=0 at the next edge; cause=3'b010; full sequence repeats after DEPTH+HOLD_CYCLES edges.
- rst_req[0] pulses during RELEASE after rst_out[0] has been released -> rst_out[0] reasserts; rst_out[1] is never released before rst_out[0]; release restarts from channel 0.
- enable low for 5 cycles mid-HOLD -> all release times shift by exactly 5 edges; rst_out stays all 1 throughout.
- rst_n driven low mid-RELEASE -> rst_out all 1 and rst_out_n all 0 immediately, without a clock edge; cause=3'b100.
- rst_req[0] and rst_req[1] asserted on the same edge in RUN -> cause=3'b011; release timing is the same as in the single-source case.
